// File: rtl/encode_pkg.sv
// Shared definitions for the index encode/decode blocks.
package encode_pkg;

  // Default mask width, shared with priority_encode.
  localparam int unsigned ENC_DEFAULT_N = 255;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } idx_dec_state_t;

endpackage : encode_pkg

// File: rtl/onehot_decode.sv
// Combinational index-to-one-hot decoder with out-of-range flag.
module onehot_decode
  import encode_pkg::*;
#(
  parameter  int unsigned N = ENC_DEFAULT_N,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         en,
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         oor
);

  localparam logic [W:0] N_LIM = (W+1)'(N);

  logic idx_oor;

  assign idx_oor = ({1'b0, idx} >= N_LIM);
  assign oor     = en && idx_oor;

  // One bit per legal index; all-zero when disabled or out of range.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = en && !idx_oor && (idx == W'(i));
    end
  end

endmodule : onehot_decode

// File: rtl/index_decode.sv
// Accumulates a stream of bit indices into an N-bit mask per frame and
// emits mask, distinct count and error flags on the frame's last beat.
module index_decode
  import encode_pkg::*;
#(
  parameter  int unsigned N  = ENC_DEFAULT_N,
  localparam int unsigned W  = $clog2(N),
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_idx,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_mask,
  output logic [CW-1:0] out_count,
  output logic          out_err,
  output logic          out_dup
);

  idx_dec_state_t state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;
  logic           dup_q, dup_d;

  logic           accept;
  logic [N-1:0]   hit;
  logic           hit_oor;
  logic           hit_dup;

  assign accept  = in_valid && (state_q == ACCUM);
  assign hit_dup = |(hit & mask_q);

  onehot_decode #(.N(N)) u_onehot (
    .en     (accept),
    .idx    (in_idx),
    .onehot (hit),
    .oor    (hit_oor)
  );

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    err_d   = err_q;
    dup_d   = dup_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (hit_oor) begin
            err_d = 1'b1;
          end else if (hit_dup) begin
            dup_d = 1'b1;
          end else begin
            mask_d  = mask_q | hit;
            count_d = count_q + CW'(1);
          end
          if (in_last) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = ACCUM;
          mask_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
          dup_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and accumulator registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      err_q   <= err_d;
      dup_q   <= dup_d;
    end
  end

  // Handshake flags decode the registered state only; no path from out_ready.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == EMIT);
  assign out_mask  = mask_q;
  assign out_count = count_q;
  assign out_err   = err_q;
  assign out_dup   = dup_q;

endmodule : index_decode

// File: tb/tb_index_decode.sv
// Directed self-checking bench for index_decode.
module tb_index_decode;

  localparam int unsigned N  = 255;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_idx;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_mask;
  logic [CW-1:0] out_count;
  logic          out_err;
  logic          out_dup;

  int n_assert;
  int n_fail;

  logic [N-1:0] exp_mask;
  logic [N-1:0] held_mask;

  index_decode #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_err   (out_err),
    .out_dup   (out_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and wait (bounded) until it is accepted.
  task automatic send(input int idx, input logic last);
    logic taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_idx   = W'(idx);
    in_last  = last;
    for (int c = 0; c < 20 && !taken; c++) begin
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) chk("send_timeout", 256'd0, 256'd1);
  endtask

  // Complete the output handshake (bounded wait on out_valid).
  task automatic drain();
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!out_valid) chk("drain_timeout", 256'd0, 256'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [N-1:0] m, input int cnt,
                            input logic e, input logic d);
    chk({tag, "_valid"}, 256'(out_valid), 256'd1);
    chk({tag, "_ready"}, 256'(in_ready), 256'd0);
    chk({tag, "_mask"},  256'(out_mask), 256'(m));
    chk({tag, "_count"}, 256'(out_count), 256'(cnt));
    chk({tag, "_err"},   256'(out_err), 256'(e));
    chk({tag, "_dup"},   256'(out_dup), 256'(d));
  endtask

  initial begin
    int hi;
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready",  256'(in_ready), 256'd1);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_mask",      256'(out_mask), 256'd0);
    chk("rst_count",     256'(out_count), 256'd0);
    chk("rst_err",       256'(out_err), 256'd0);
    chk("rst_dup",       256'(out_dup), 256'd0);

    // Frame 1: 3, 254, 0(last)
    send(3, 1'b0);
    send(254, 1'b0);
    send(0, 1'b1);
    exp_mask = '0;
    exp_mask[0] = 1'b1;
    exp_mask[3] = 1'b1;
    exp_mask[254] = 1'b1;
    chk_result("f1", exp_mask, 3, 1'b0, 1'b0);
    drain();
    chk("f1_clr_valid", 256'(out_valid), 256'd0);
    chk("f1_clr_mask",  256'(out_mask), 256'd0);
    chk("f1_clr_ready", 256'(in_ready), 256'd1);

    // Frame 2: duplicate
    send(5, 1'b0);
    send(5, 1'b0);
    send(7, 1'b1);
    exp_mask = '0;
    exp_mask[5] = 1'b1;
    exp_mask[7] = 1'b1;
    chk_result("f2", exp_mask, 2, 1'b0, 1'b1);
    drain();

    // Frame 3: out-of-range index
    send(255, 1'b0);
    send(10, 1'b1);
    exp_mask = '0;
    exp_mask[10] = 1'b1;
    chk_result("f3", exp_mask, 1, 1'b1, 1'b0);

    // Back-pressure with a pending one-beat frame (index 20)
    held_mask = exp_mask;
    in_valid  = 1'b1;
    in_idx    = W'(20);
    in_last   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", 256'(in_ready), 256'd0);
      chk("hold_valid", 256'(out_valid), 256'd1);
      chk("hold_mask",  256'(out_mask), 256'(held_mask));
      chk("hold_count", 256'(out_count), 256'd1);
      chk("hold_err",   256'(out_err), 256'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_valid", 256'(out_valid), 256'd0);
    chk("hs_ready", 256'(in_ready), 256'd1);
    chk("hs_mask",  256'(out_mask), 256'd0);
    chk("hs_count", 256'(out_count), 256'd0);
    chk("hs_err",   256'(out_err), 256'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_mask = '0;
    exp_mask[20] = 1'b1;
    chk_result("pend", exp_mask, 1, 1'b0, 1'b0);
    drain();

    // Full frame 0..254
    for (int i = 0; i < 255; i++) send(i, (i == 254));
    exp_mask = '1;
    chk_result("full", exp_mask, 255, 1'b0, 1'b0);
    hi = -1;
    for (int i = 0; i < 255; i++) if (out_mask[i]) hi = i;
    chk("full_prio", 256'(hi), 256'd254);
    drain();

    // Reset mid-frame
    send(1, 1'b0);
    send(2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mrst_ready", 256'(in_ready), 256'd1);
    chk("mrst_mask",  256'(out_mask), 256'd0);
    chk("mrst_count", 256'(out_count), 256'd0);
    send(9, 1'b1);
    exp_mask = '0;
    exp_mask[9] = 1'b1;
    chk_result("mrst", exp_mask, 1, 1'b0, 1'b0);

    // Reset during EMIT drops the result
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("erst_valid", 256'(out_valid), 256'd0);
    chk("erst_mask",  256'(out_mask), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_index_decode

// File: doc/index_decode.md
# index_decode

Sequential inverse of the priority encoder. It accepts a stream of bit indices over a valid/ready handshake and sets the corresponding bits of an N-bit mask. On the frame's last beat it emits the assembled mask, plus a distinct-bit count and error flags, over a second valid/ready handshake. It sits upstream of `priority_encode`, so a mask built here can be re-encoded to recover its highest set index.

## Interface
Parameters:
- `N`, 255, mask width; legal indices are 0..N-1.
- `W`, $clog2(N) (8), index width. Derived; do not override.
- `CW`, $clog2(N+1) (8), count width. Derived.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  index beat valid.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_idx`  in  W  bit index to set.
- `in_last`  in  1  beat closes the frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_mask`  out  N  accumulated mask.
- `out_count`  out  CW  number of distinct legal bits set.
- `out_err`  out  1  at least one beat had `in_idx` >= N.
- `out_dup`  out  1  at least one legal index repeated within the frame.

## Operation
- Two states: ACCUM and EMIT.
- ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - An accepted beat (`in_valid`&&`in_ready`) is handled by index:
    - `in_idx` < N and the bit is clear: set the bit and increment the count.
    - `in_idx` < N and the bit is already set: set the dup flag; mask and count are unchanged.
    - `in_idx` >= N: set the err flag; mask and count are unchanged.
  - An accepted beat with `in_last`=1 applies its own update, then moves to EMIT.
- EMIT:
  - `in_ready`=0, `out_valid`=1.
  - Outputs are held stable until `out_ready`=1.
  - On handshake, mask, count, err and dup all clear to 0 and the state returns to ACCUM.
- Every frame has at least one beat. A frame whose only beat has `in_last`=1 is a one-beat frame.
- `out_mask`, `out_count`, `out_err` and `out_dup` are registered and driven directly from the accumulators. Values in ACCUM are partial and are don't-care to consumers.
- `out_count` never exceeds N; since N is at most 2^CW−1 it cannot wrap.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - state ACCUM;
  - `out_mask`=0, `out_count`=0, `out_err`=0, `out_dup`=0, `out_valid`=0;
  - `in_ready`=1 from the following cycle.
- Reset mid-frame discards the partial frame. Reset during EMIT drops the pending result with no handshake.
- Throughput is one beat per cycle in ACCUM.
- Latency: if the last beat is accepted at edge t, `out_valid`=1 in the cycle after t.
- `in_ready` is a registered function of state only, with no combinational path from `out_ready`. Consequently:
  - at least one cycle of `in_ready`=0 separates frames;
  - the earliest first beat of the next frame is accepted at the edge after the output handshake.
- A beat presented while `in_ready`=0 is not consumed; the upstream holds it.
- Within one beat, an index that is both out of range and a repeat cannot occur; the range check takes priority.

## Structure
- Package `encode_pkg` holds:
  - a default-N constant, shared with `priority_encode`;
  - the state enum `idx_dec_state_t` {ACCUM, EMIT}.
- Sub-module `onehot_decode` #(N):
  - combinational; inputs `en` and `idx`; output an N-bit one-hot;
  - all-zero when `en`=0 or `idx` >= N;
  - also produces an `oor` flag for out-of-range indices.
- The top level does the accumulation: OR the one-hot into the mask, and test it against the existing mask for duplicates.
- Expected size is about 150 lines including the sub-module.

## Test plan
- After reset, check `in_ready`=1, `out_valid`=0 and all outputs 0. Then send beats 3, 254, 0(last) → one cycle later: `out_mask` bits {0,3,254} set, `out_count`=3, `out_err`=0, `out_dup`=0.
- Send beats 5, 5, 7(last) → mask bits {5,7}, `out_count`=2, `out_dup`=1.
- Send beats 255, 10(last) → mask bit {10}, `out_count`=1, `out_err`=1.
- Hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 → `in_ready`=0 and outputs stable throughout. Then raise `out_ready` → next cycle outputs cleared, the pending beat accepted, and the next frame starts with a clean mask.
- Send beats 0..254 back-to-back with last on 254 → all-ones mask and `out_count`=255. Feed `out_mask` to `priority_encode` with `en`=1 → result 254.
- Assert `rst_n`=0 for 1 cycle mid-frame after beats 1, 2, then send 9(last) → mask bit {9} only, `out_count`=1.
